// File: rtl/fetch_pair_queue.sv
// fetch_pair_queue
// Dual-slot instruction fetch stage. Issues the (pcF1, pcF2) pair to a
// synchronous-read instruction memory, captures the returned instruction
// pair with its PCs one cycle later, and queues it for decode behind a
// valid/ready handshake. A credit check over queued plus in-flight pairs
// drives fetch_stall so a returning read always finds a free slot.
//
// Optional feature macro: FETCH_BYPASS_EN
//   When defined, a pair returning into an empty queue is presented to
//   decode combinationally in its arrival cycle and is not written if
//   decode takes it immediately.
module fetch_pair_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [31:0] pcF1,
  input  logic [31:0] pcF2,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr1,
  output logic [31:0] imem_addr2,
  input  logic [31:0] imem_rdata1,
  input  logic [31:0] imem_rdata2,
  output logic        fetch_stall,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc1,
  output logic [31:0] dec_pc2,
  output logic [31:0] dec_instr1,
  output logic [31:0] dec_instr2
);

  localparam int DATA_W = 32;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int OCC_W  = CNT_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] pc1;
    logic [DATA_W-1:0] pc2;
    logic [DATA_W-1:0] instr1;
    logic [DATA_W-1:0] instr2;
  } entry_t;

  // Queue storage and control
  entry_t           q_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  // Stage-1: request issued last cycle, data returning this cycle
  logic              s1_valid;
  logic [DATA_W-1:0] s1_pc1;
  logic [DATA_W-1:0] s1_pc2;

  logic [OCC_W-1:0] occupancy;
  logic             space;
  logic             q_nonempty;
  logic             push;
  logic             pop;
  logic             byp_active;
  logic             byp_take;
  entry_t           arriving;
  entry_t           head;

  // Memory addresses follow the PC generator directly.
  assign imem_addr1 = pcF1;
  assign imem_addr2 = pcF2;

  // Credit: queued pairs plus the one possibly in flight must leave a slot.
  // A pop in this cycle is deliberately not counted, keeping fetch_stall
  // independent of dec_ready.
  assign occupancy   = OCC_W'(count) + OCC_W'(s1_valid);
  assign space       = occupancy < OCC_W'(DEPTH);
  assign fetch_stall = ~space;
  assign imem_req    = fetch_valid & space & ~flush & ~rst;

  assign q_nonempty = (count != '0);
  assign arriving   = {s1_pc1, s1_pc2, imem_rdata1, imem_rdata2};
  assign head       = q_mem[rd_ptr];

`ifdef FETCH_BYPASS_EN
  // Arriving pair is visible to decode when nothing older is queued.
  assign byp_active = ~q_nonempty & s1_valid & ~flush;
`else
  assign byp_active = 1'b0;
`endif
  assign byp_take = byp_active & dec_ready;

  assign pop  = q_nonempty & dec_ready;
  assign push = s1_valid & ~byp_take;

  // Present the head entry (or the bypassed arrival); zeros when idle.
  always_comb begin
    dec_valid  = 1'b0;
    dec_pc1    = '0;
    dec_pc2    = '0;
    dec_instr1 = '0;
    dec_instr2 = '0;
    if (q_nonempty) begin
      dec_valid  = 1'b1;
      dec_pc1    = head.pc1;
      dec_pc2    = head.pc2;
      dec_instr1 = head.instr1;
      dec_instr2 = head.instr2;
    end else if (byp_active) begin
      dec_valid  = 1'b1;
      dec_pc1    = arriving.pc1;
      dec_pc2    = arriving.pc2;
      dec_instr1 = arriving.instr1;
      dec_instr2 = arriving.instr2;
    end
  end

  // Queue control: occupancy, pointers and the stage-1 valid; flush wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      s1_valid <= 1'b0;
    end else if (flush) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= imem_req;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!push && pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Stage-1 PCs: capture the pair whose read was just issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_pc1 <= RESET_PC;
      s1_pc2 <= RESET_PC;
    end else if (imem_req) begin
      s1_pc1 <= pcF1;
      s1_pc2 <= pcF2;
    end
  end

  // Queue write: returning pair lands at wr_ptr; dropped on flush.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      q_mem[wr_ptr] <= arriving;
    end
  end

endmodule
